// File: rtl/rr_arb_top.sv
// -----------------------------------------------------------------------------
// rr_arb_top
//
// Round-robin arbiter for REQCNT requesters. One requester is granted per
// arbitration cycle. The registered grant index req_num_o is also the priority
// pointer: the search for the next winner starts just after the current holder
// and wraps round, so the holder has the lowest priority.
//
// Parameters:
//   REQCNT      number of requesters, 2..64; non-power-of-two values allowed
//
// Ports:
//   clk_i       clock; all state changes on the rising edge
//   rst_i       synchronous active-high reset; forces req_num_o to 0
//   req_i       request vector, bit i = requester i pending
//   req_val_i   arbitration enable; a new decision is made only when high
//   req_num_o   registered index of the currently granted requester
//   gnt_val_o   (only with RR_ARB_GNT_VAL_EN) registered, 1 for the cycle
//               after an edge on which a grant was actually made
//
// Optional feature macro: RR_ARB_GNT_VAL_EN
// -----------------------------------------------------------------------------
module rr_arb_top #(
  parameter int REQCNT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REQCNT-1:0]         req_i,
  input  logic                      req_val_i,
  output logic [$clog2(REQCNT)-1:0] req_num_o
`ifdef RR_ARB_GNT_VAL_EN
  ,
  output logic                      gnt_val_o
`endif
);

  localparam int IDXW = $clog2(REQCNT);

  logic [IDXW-1:0] next_idx_s;
  logic [IDXW-1:0] cand_s;
  logic            found_s;
  logic            grant_s;
  int              sum_s;

  // A decision is taken only when enabled and at least one requester is pending.
  assign grant_s = req_val_i & (|req_i);

  // Rotating search: holder+1, holder+2, ... wrapping at REQCNT, holder last.
  // The sum never exceeds 2*REQCNT-1, so a single conditional subtract is a
  // full modulo and encodings >= REQCNT can never be produced.
  always_comb begin
    found_s    = 1'b0;
    next_idx_s = req_num_o;
    cand_s     = '0;
    sum_s      = 32'sd0;
    for (int k = 1; k <= REQCNT; k++) begin
      sum_s = int'(req_num_o) + k;
      if (sum_s >= REQCNT) begin
        cand_s = IDXW'(sum_s - REQCNT);
      end else begin
        cand_s = IDXW'(sum_s);
      end
      if (!found_s && req_i[cand_s]) begin
        found_s    = 1'b1;
        next_idx_s = cand_s;
      end else begin
        found_s    = found_s;
        next_idx_s = next_idx_s;
      end
    end
  end

  // Grant/pointer register: reset wins, otherwise load the winner or hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_num_o <= '0;
    end else if (grant_s) begin
      req_num_o <= next_idx_s;
    end else begin
      req_num_o <= req_num_o;
    end
  end

`ifdef RR_ARB_GNT_VAL_EN
  // Fresh-grant flag: distinguishes a newly made grant from a held index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_val_o <= 1'b0;
    end else begin
      gnt_val_o <= grant_s;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_top.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_top
//
// Scoreboarded bench for rr_arb_top. Two instances are exercised: REQCNT=4
// (directed plus long randomised run with a fairness watch) and REQCNT=3
// (non-power-of-two wrap plus a short randomised run). The driver pushes the
// reference model's expectation for every edge it drives; an independent
// monitor pops and compares one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_rr_arb_top;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b1;
  logic       val4 = 1'b0;
  logic [3:0] req4 = 4'b0000;
  logic [1:0] num4;
  logic       rst3 = 1'b1;
  logic       val3 = 1'b0;
  logic [2:0] req3 = 3'b000;
  logic [1:0] num3;
`ifdef RR_ARB_GNT_VAL_EN
  logic       gnt4;
  logic       gnt3;
`endif

  rr_arb_top #(.REQCNT(4)) dut4 (
    .clk_i     (clk),
    .rst_i     (rst4),
    .req_i     (req4),
    .req_val_i (val4),
    .req_num_o (num4)
`ifdef RR_ARB_GNT_VAL_EN
    ,
    .gnt_val_o (gnt4)
`endif
  );

  rr_arb_top #(.REQCNT(3)) dut3 (
    .clk_i     (clk),
    .rst_i     (rst3),
    .req_i     (req3),
    .req_val_i (val3),
    .req_num_o (num3)
`ifdef RR_ARB_GNT_VAL_EN
    ,
    .gnt_val_o (gnt3)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic       val;
    int         exp;
    logic       exp_gnt;
    bit         fair;
  } item_t;

  item_t q4[$];
  item_t q3[$];
  int    m4 = 0;
  int    m3 = 0;
  bit    fair_on = 1'b0;
  int    wait_cnt [4];
  int    n_chk = 0;
  int    n_pass = 0;

  // Behavioural rule: first pending index strictly after the holder, wrapping.
  function automatic int rr_next(int p, logic [3:0] req, logic v, logic r, int n);
    if (r) return 0;
    if (!v || req == 4'b0000) return p;
    for (int k = 1; k <= n; k++) begin
      if (req[(p + k) % n]) return (p + k) % n;
    end
    return p;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive4(logic r, logic v, logic [3:0] q);
    item_t it;
    @(negedge clk);
    rst4 = r; val4 = v; req4 = q;
    rst3 = 1'b0; val3 = 1'b0;
    m4 = rr_next(m4, q, v, r, 4);
    it.req = q; it.val = v; it.exp = m4;
    it.exp_gnt = !r && v && (q != 4'b0000);
    it.fair = fair_on;
    q4.push_back(it);
  endtask

  task automatic drive3(logic r, logic v, logic [2:0] q);
    item_t it;
    @(negedge clk);
    rst3 = r; val3 = v; req3 = q;
    rst4 = 1'b0; val4 = 1'b0;
    m3 = rr_next(m3, {1'b0, q}, v, r, 3);
    it.req = {1'b0, q}; it.val = v; it.exp = m3;
    it.exp_gnt = !r && v && (q != 3'b000);
    it.fair = 1'b0;
    q3.push_back(it);
  endtask

  // Monitor: compares each DUT against the expectation queued for that edge.
  initial begin
    item_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("idx4", {30'd0, num4}, e.exp);
`ifdef RR_ARB_GNT_VAL_EN
        check("gnt4", {31'd0, gnt4}, {31'd0, e.exp_gnt});
`endif
        if (e.fair && e.val) begin
          for (int i = 0; i < 4; i++) begin
            if (e.req[i] && int'(num4) != i) begin
              wait_cnt[i]++;
              n_chk++;
              if (wait_cnt[i] <= 3) n_pass++;
              else $display("FAIL fair%0d: waited %0d edges, allowed 3", i, wait_cnt[i]);
            end else begin
              wait_cnt[i] = 0;
            end
          end
        end
      end
      if (q3.size() != 0) begin
        e = q3.pop_front();
        check("idx3", {30'd0, num3}, e.exp);
`ifdef RR_ARB_GNT_VAL_EN
        check("gnt3", {31'd0, gnt3}, {31'd0, e.exp_gnt});
`endif
      end
    end
  end

  // Stimulus: directed test-plan sequences, then randomised traffic.
  initial begin
    logic [3:0] cur;
    logic [3:0] nxt;
    logic [2:0] r3;

    // Reset with everything requesting, then full-load rotation 1,2,3,0,1,2.
    drive4(1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 6; i++) drive4(1'b0, 1'b1, 4'b1111);
    drive4(1'b0, 1'b1, 4'b1111);          // reaches 3
    drive4(1'b1, 1'b1, 4'b1111);          // reset mid-sequence -> 0

    // Single requester, then no requests -> hold.
    drive4(1'b0, 1'b1, 4'b0100);
    drive4(1'b0, 1'b1, 4'b0100);
    drive4(1'b0, 1'b1, 4'b0000);

    // Enable low holds the index; raising it resumes rotation 3 then 1.
    drive4(1'b0, 1'b1, 4'b0010);
    for (int i = 0; i < 3; i++) drive4(1'b0, 1'b0, 4'b1010);
    drive4(1'b0, 1'b1, 4'b1010);
    drive4(1'b0, 1'b1, 4'b1010);

    // Non-power-of-two wrap on REQCNT=3: 2 -> 0 -> 1 -> 0.
    drive3(1'b1, 1'b1, 3'b111);
    drive3(1'b0, 1'b1, 3'b100);
    for (int i = 0; i < 3; i++) drive3(1'b0, 1'b1, 3'b011);

    // Random REQCNT=3 traffic including occasional resets and enable drops.
    for (int i = 0; i < 500; i++) begin
      r3 = 3'($urandom_range(7, 0));
      drive3(($urandom_range(31, 0) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0, r3);
    end

    // Random REQCNT=4 fairness run: requests held until served.
    fair_on = 1'b1;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    cur = 4'b0000;
    for (int i = 0; i < 10000; i++) begin
      nxt = cur;
      if (nxt[m4] && $urandom_range(1, 0) == 1) nxt[m4] = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (!nxt[b] && $urandom_range(3, 0) == 0) nxt[b] = 1'b1;
      end
      drive4(1'b0, |nxt, nxt);
      cur = nxt;
    end
    fair_on = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    check("drain", q4.size() + q3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
